// File: rtl/layer_mux_n.sv
// layer_mux_n -- priority layer multiplexer with fade-out/fade-in and optional
// per-layer collision detection.
//
// Pipeline: stage 1 registers the colour of the highest-priority active layer
// (lowest index with drawReq & layerEn), or backGroundRGB when none is active.
// Stage 2 expands RGB332 to 24-bit and scales every channel by the fade level
// (0..8, >>3). Input-to-output latency is exactly 2 cycles.
//
// Fade FSM: IDLE (level 8) -> FADE_OUT -> HOLD (level 0) -> FADE_IN -> IDLE.
// The level steps by one every FADE_STEP_FRAMES startOfFrame pulses.
//
// Optional feature: define LAYER_MUX_COLLISION_EN to build the collision
// accumulator; otherwise collisionMask / collisionValid are tied to 0.
//
// Ports:
//   clk, resetN            pixel clock, async active-low reset
//   drawReq[N]             per-layer draw request
//   layerRGB[N][8]         per-layer RGB332 colour
//   backGroundRGB[8]       colour when no layer is drawn
//   layerEn[N]             per-layer enable
//   startOfFrame           pulse at first pixel of each frame
//   fadeStart              request to start a fade-out / fade-in
//   fadeBusy, fadeDone     fade status
//   collisionMask[N]       per-layer collision flags of the previous frame
//   collisionValid         pulse when collisionMask updates
//   redOut/greenOut/blueOut  scaled 24-bit colour

module layer_chan_scale (
  input  logic [7:0] ch,
  input  logic [3:0] level,
  output logic [7:0] scaled
);
  logic [11:0] prod;
  // level 8 -> ch exactly, level 0 -> 0
  assign prod   = {4'b0, ch} * {8'b0, level};
  assign scaled = prod[10:3];
endmodule

module layer_mux_n #(
  parameter int NUM_LAYERS       = 8,
  parameter int FADE_STEP_FRAMES = 4
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic [NUM_LAYERS-1:0]      drawReq,
  input  logic [NUM_LAYERS-1:0][7:0] layerRGB,
  input  logic [7:0]                 backGroundRGB,
  input  logic [NUM_LAYERS-1:0]      layerEn,
  input  logic                       startOfFrame,
  input  logic                       fadeStart,
  output logic                       fadeBusy,
  output logic                       fadeDone,
  output logic [NUM_LAYERS-1:0]      collisionMask,
  output logic                       collisionValid,
  output logic [7:0]                 redOut,
  output logic [7:0]                 greenOut,
  output logic [7:0]                 blueOut
);

  localparam logic [7:0] STEP_LAST = 8'(FADE_STEP_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, FADE_OUT, HOLD, FADE_IN} fade_state_t;

  logic [NUM_LAYERS-1:0] hits;
  logic [7:0]            sel_rgb, color_q;
  logic [2:0][7:0]       expanded, scaled;

  fade_state_t state, state_n;
  logic [3:0]  level, level_n;
  logic [7:0]  frame_cnt, frame_cnt_n;

  assign hits = drawReq & layerEn;

  // Priority select: walk from the lowest priority up so index 0 wins.
  always_comb begin
    sel_rgb = backGroundRGB;
    for (int i = NUM_LAYERS - 1; i >= 0; i--)
      if (hits[i]) sel_rgb = layerRGB[i];
  end

  // Stage 1
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) color_q <= '0;
    else         color_q <= sel_rgb;

  // RGB332 -> 888 by bit replication
  assign expanded[2] = {color_q[7:5], color_q[7:5], color_q[7:6]};
  assign expanded[1] = {color_q[4:2], color_q[4:2], color_q[4:3]};
  assign expanded[0] = {color_q[1:0], color_q[1:0], color_q[1:0], color_q[1:0]};

  for (genvar c = 0; c < 3; c++) begin : g_chan
    layer_chan_scale u_scale (
      .ch     (expanded[c]),
      .level  (level),
      .scaled (scaled[c])
    );
  end

  // Stage 2
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      redOut   <= '0;
      greenOut <= '0;
      blueOut  <= '0;
    end else begin
      redOut   <= scaled[2];
      greenOut <= scaled[1];
      blueOut  <= scaled[0];
    end

  // Fade FSM: state register
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state     <= IDLE;
      level     <= 4'd8;
      frame_cnt <= '0;
    end else begin
      state     <= state_n;
      level     <= level_n;
      frame_cnt <= frame_cnt_n;
    end

  // Fade FSM: next state. A startOfFrame coinciding with the fadeStart that
  // leaves IDLE/HOLD is dropped because those states never count frames.
  always_comb begin
    state_n     = state;
    level_n     = level;
    frame_cnt_n = frame_cnt;
    case (state)
      IDLE: if (fadeStart) begin
        state_n     = FADE_OUT;
        frame_cnt_n = '0;
      end
      HOLD: if (fadeStart) begin
        state_n     = FADE_IN;
        frame_cnt_n = '0;
      end
      FADE_OUT: if (startOfFrame) begin
        if (frame_cnt == STEP_LAST) begin
          frame_cnt_n = '0;
          level_n     = level - 4'd1;
          if (level == 4'd1) state_n = HOLD;
        end else begin
          frame_cnt_n = frame_cnt + 8'd1;
        end
      end
      FADE_IN: if (startOfFrame) begin
        if (frame_cnt == STEP_LAST) begin
          frame_cnt_n = '0;
          level_n     = level + 4'd1;
          if (level == 4'd7) state_n = IDLE;
        end else begin
          frame_cnt_n = frame_cnt + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Fade FSM: outputs
  always_comb begin
    fadeBusy = (state == FADE_OUT) || (state == FADE_IN);
    fadeDone = (state == HOLD);
  end

`ifdef LAYER_MUX_COLLISION_EN
  logic [NUM_LAYERS-1:0] coll_acc, coll_now;
  logic                  multi_hit;

  // Two or more enabled layers requesting: every requesting layer collides.
  assign multi_hit = (hits & (hits - 1'b1)) != '0;
  assign coll_now  = multi_hit ? hits : '0;

  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      coll_acc       <= '0;
      collisionMask  <= '0;
      collisionValid <= 1'b0;
    end else begin
      collisionValid <= startOfFrame;
      if (startOfFrame) begin
        collisionMask <= coll_acc | coll_now;
        coll_acc      <= '0;
      end else begin
        coll_acc      <= coll_acc | coll_now;
      end
    end
`else
  assign collisionMask  = '0;
  assign collisionValid = 1'b0;
`endif

endmodule
